// File: rtl/router_pkg.sv
// Shared router definitions: packet header layout inside a unit, output-port
// FSM encoding and the port identifiers used by dispatcher and arbiter.
package router_pkg;

    // Word offsets of the packet header inside a unit
    localparam int unsigned SRC_ID    = 32'd0;
    localparam int unsigned DEST_ID   = 32'd1;
    localparam int unsigned LEN_OFS   = 32'd2;
    localparam int unsigned HDR_WORDS = 32'd3;

    // Output-port FSM encoding (kept as plain constants for older tools)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_CAPT    = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    // Output port identifiers, one per output port instance
    localparam logic [1:0] PORT_ID_0 = 2'd0;
    localparam logic [1:0] PORT_ID_1 = 2'd1;
    localparam logic [1:0] PORT_ID_2 = 2'd2;
    localparam int unsigned NUM_PORTS = 32'd3;

endpackage

// File: rtl/router_output_port_if.sv
// Bus bundle of one router output port: the arbitrated unit-memory read port
// and the valid/ready output word stream. The port drives the master side.
interface router_output_port_if #(
    parameter int UWIDTH    = 8,
    parameter int PTR_SZ    = 2,
    parameter int PTR_IN_SZ = 4
);
    // Unit memory read port
    logic                 mem_req;
    logic [1:0]           mem_port_id;
    logic [PTR_SZ-1:0]    mem_addr;
    logic [PTR_IN_SZ-1:0] mem_addr_in;
    logic                 mem_gnt;
    logic [UWIDTH-1:0]    mem_rdata;

    // Output word stream
    logic                 out_valid;
    logic [UWIDTH-1:0]    out_data;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output mem_req, mem_port_id, mem_addr, mem_addr_in,
        output out_valid, out_data, out_last,
        input  mem_gnt, mem_rdata, out_ready
    );

    modport slave (
        input  mem_req, mem_port_id, mem_addr, mem_addr_in,
        input  out_valid, out_data, out_last,
        output mem_gnt, mem_rdata, out_ready
    );

endinterface

// File: rtl/router_output_port.sv
// Router output port: takes a dispatch job (slot address), reads the packet
// of that unit word by word through the arbitrated memory port, streams it
// out on valid/ready and pulses read_done so the slot can be recycled.
// The packet length is learned from header word 2; lengths that overflow
// the unit are clamped to the unit size and flagged on len_err.
module router_output_port
    import router_pkg::*;
#(
    parameter int         UWIDTH    = 8,
    parameter int         PTR_SZ    = 2,
    parameter int         PTR_IN_SZ = 4,
    parameter logic [1:0] PORT_ID   = PORT_ID_0
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              read_en,
    input  logic [PTR_SZ-1:0] raddr,
    output logic              read_done,
    output logic              busy,
    output logic              len_err,
    router_output_port_if.master bus
);

    // Wide enough to hold HDR_WORDS + max LEN and the unit capacity
    localparam int SUMW = ((UWIDTH > PTR_IN_SZ) ? UWIDTH : PTR_IN_SZ) + 2;
    localparam logic [SUMW-1:0] UNIT_WORDS_S = SUMW'(1) << PTR_IN_SZ;

    logic [2:0]           state_r;
    logic [PTR_IN_SZ:0]   tot_r;        // total words of the packet (clamped)
    logic                 tot_known_r;  // tot_r valid once the LEN word is read
    logic                 err_r;        // LEN overflowed the unit

    logic [SUMW-1:0]      len_sum_s;
    logic [PTR_IN_SZ:0]   tot_new_s;
    logic                 err_new_s;
    logic [PTR_IN_SZ:0]   idx_next_s;
    logic                 last_s;

    assign bus.mem_port_id = PORT_ID;

    // Packet size from the LEN word and last-word detection for the word in flight
    always_comb begin
        len_sum_s  = SUMW'(bus.mem_rdata) + SUMW'(HDR_WORDS);
        idx_next_s = {1'b0, bus.mem_addr_in} + (PTR_IN_SZ+1)'(1);
        tot_new_s  = '0;
        err_new_s  = 1'b0;
        last_s     = 1'b0;
        if (len_sum_s > UNIT_WORDS_S) begin
            tot_new_s = UNIT_WORDS_S[PTR_IN_SZ:0];
            err_new_s = 1'b1;
        end else begin
            tot_new_s = len_sum_s[PTR_IN_SZ:0];
            err_new_s = 1'b0;
        end
        if (bus.mem_addr_in == PTR_IN_SZ'(LEN_OFS)) begin
            last_s = (idx_next_s == tot_new_s);
        end else if (tot_known_r) begin
            last_s = (idx_next_s == tot_r);
        end else begin
            last_s = 1'b0;
        end
    end

    // Job FSM with registered memory request, output word and status outputs
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            tot_r           <= '0;
            tot_known_r     <= 1'b0;
            err_r           <= 1'b0;
            read_done       <= 1'b0;
            busy            <= 1'b0;
            len_err         <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_addr_in <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_last    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (read_en) begin
                        bus.mem_addr    <= raddr;
                        bus.mem_addr_in <= '0;
                        bus.mem_req     <= 1'b1;
                        busy            <= 1'b1;
                        tot_r           <= '0;
                        tot_known_r     <= 1'b0;
                        err_r           <= 1'b0;
                        state_r         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state_r     <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    bus.out_data  <= bus.mem_rdata;
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= last_s;
                    if (bus.mem_addr_in == PTR_IN_SZ'(LEN_OFS)) begin
                        tot_r       <= tot_new_s;
                        tot_known_r <= 1'b1;
                        err_r       <= err_new_s;
                    end
                    state_r <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (bus.out_last) begin
                            read_done <= 1'b1;
                            len_err   <= err_r;
                            err_r     <= 1'b0;
                            state_r   <= ST_DONE;
                        end else begin
                            bus.mem_addr_in <= bus.mem_addr_in + PTR_IN_SZ'(1);
                            bus.mem_req     <= 1'b1;
                            state_r         <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    read_done <= 1'b0;
                    len_err   <= 1'b0;
                    state_r   <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // 4-phase handshake: a still-high read_en is the old job
                    if (!read_en) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    busy          <= 1'b0;
                    read_done     <= 1'b0;
                    len_err       <= 1'b0;
                    bus.mem_req   <= 1'b0;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_output_port.sv
// Bench for router_output_port: unit memory + arbiter responder, downstream
// sink with programmable stalls, and a scoreboard of expected output words.
module tb_router_output_port;
    import router_pkg::*;

    localparam int UW  = 8;
    localparam int PS  = 2;
    localparam int PIS = 4;

    logic          clk2 = 1'b0;
    logic          rst = 1'b1;
    logic          read_en = 1'b0;
    logic [PS-1:0] raddr = '0;
    logic          read_done, busy, len_err;

    router_output_port_if #(.UWIDTH(UW), .PTR_SZ(PS), .PTR_IN_SZ(PIS)) bus ();

    router_output_port #(.UWIDTH(UW), .PTR_SZ(PS), .PTR_IN_SZ(PIS), .PORT_ID(PORT_ID_1)) dut (
        .clk2(clk2), .rst(rst), .read_en(read_en), .raddr(raddr),
        .read_done(read_done), .busy(busy), .len_err(len_err), .bus(bus)
    );

    always #5 clk2 = ~clk2;

    logic [7:0] mem [4][16];
    logic [8:0] exp_q [$];      // {last, data}
    int         acc_q [$];      // cycle stamp of each accepted word

    int errors = 0, checks = 0;
    int cyc = 0, rx_cnt = 0, done_cnt = 0, stray_lerr = 0;
    int gnt_cnt = 0, req_drops = 0;
    int gnt_delay = 0, stall_word = -1, stall_left = 0;
    logic stray_gnt = 1'b1, ready_idle = 1'b1, done_lerr = 1'b0;

    // Memory/arbiter responder: grant after gnt_delay waiting cycles, data one cycle later
    initial begin : mem_side
        bit pend, waiting;
        logic [PS-1:0] pa;
        logic [PIS-1:0] pi;
        int wait_n;
        pend = 0; waiting = 0; wait_n = 0; pa = '0; pi = '0;
        bus.mem_gnt = 1'b0;
        bus.mem_rdata = 8'hEE;
        forever begin
            @(negedge clk2);
            bus.mem_rdata = pend ? mem[pa][pi] : 8'hEE;
            pend = 0;
            if (waiting && !bus.mem_req && !rst) req_drops++;
            if (bus.mem_req) begin
                if (wait_n >= gnt_delay) begin
                    bus.mem_gnt = 1'b1; pend = 1; pa = bus.mem_addr; pi = bus.mem_addr_in;
                    wait_n = 0; waiting = 0; gnt_cnt++;
                end else begin
                    bus.mem_gnt = 1'b0; wait_n++; waiting = 1;
                end
            end else begin
                bus.mem_gnt = stray_gnt; wait_n = 0; waiting = 0;
            end
        end
    end

    // Downstream sink and scoreboard: pops the expected word on every accept
    initial begin : out_side
        logic [8:0] exp;
        logic [8:0] held;
        bit held_ok;
        held_ok = 0; held = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk2);
            cyc++;
            if (bus.out_valid && rx_cnt == stall_word && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
                if (held_ok) begin
                    checks++;
                    if ({bus.out_last, bus.out_data} !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got %h required %h", {bus.out_last, bus.out_data}, held);
                    end
                end
                held = {bus.out_last, bus.out_data};
                held_ok = 1;
            end else begin
                bus.out_ready = ready_idle;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %h required none", {bus.out_last, bus.out_data});
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.out_last, bus.out_data} !== exp) begin
                        errors++;
                        $display("FAIL word%0d: got last/data %h required %h", rx_cnt, {bus.out_last, bus.out_data}, exp);
                    end
                end
                rx_cnt++;
                held_ok = 0;
                acc_q.push_back(cyc);
            end
            if (read_done) begin
                done_cnt++;
                done_lerr = len_err;
            end else if (len_err) begin
                stray_lerr++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk2);
        #1;
    endtask

    task automatic start_job(input int slot);
        int tot;
        tot = 3 + int'(mem[slot][2]);
        if (tot > 16) tot = 16;
        for (int i = 0; i < tot; i++) exp_q.push_back({(i == tot - 1), mem[slot][i]});
        rx_cnt = 0;
        acc_q.delete();
        raddr = PS'(slot);
        read_en = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit to);
        int base;
        base = done_cnt;
        to = 1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt != base) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({read_done, busy, len_err, bus.mem_req, bus.out_valid, bus.out_last} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {read_done, busy, len_err, bus.mem_req, bus.out_valid, bus.out_last});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_addr_in, bus.out_data} !== 14'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h required 0", {bus.mem_addr, bus.mem_addr_in, bus.out_data});
        end
        checks++;
        if (bus.mem_port_id !== 2'd1) begin
            errors++;
            $display("FAIL port_id: got %0d required 1", bus.mem_port_id);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat, gap_bad, d0;
        bit to;
        d0 = done_cnt;
        start_job(2);
        lat = 0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            step();
            lat++;
            raddr = 2'd0;   // must not disturb the accepted job
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 3", lat);
        end
        wait_done(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: got no read_done required one"); end
        read_en = 1'b0;
        repeat (3) step();
        gap_bad = 0;
        for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != 3) gap_bad++;
        checks++;
        if (acc_q.size() != 5 || gap_bad != 0) begin
            errors++;
            $display("FAIL basic_rate: got %0d words %0d bad gaps required 5 words 0 bad gaps", acc_q.size(), gap_bad);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_lerr !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_done: got done=%0d len_err=%b left=%0d required 1 0 0", done_cnt - d0, done_lerr, exp_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_len_zero();
        int d0;
        bit to;
        d0 = done_cnt;
        start_job(1);
        wait_done(100, to);
        read_en = 1'b0;
        repeat (3) step();
        checks++;
        if (to || rx_cnt != 3 || done_cnt - d0 != 1 || done_lerr !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL len_zero: got to=%0d words=%0d done=%0d len_err=%b required 0 3 1 0", to, rx_cnt, done_cnt - d0, done_lerr);
        end
    endtask

    task automatic test_len_err();
        int d0;
        bit to;
        d0 = done_cnt;
        start_job(3);
        wait_done(200, to);
        read_en = 1'b0;
        repeat (3) step();
        checks++;
        if (to || rx_cnt != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL len_err_words: got to=%0d words=%0d required 0 16", to, rx_cnt);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_lerr !== 1'b1 || stray_lerr != 0) begin
            errors++;
            $display("FAIL len_err_flag: got done=%0d len_err=%b stray=%0d required 1 1 0", done_cnt - d0, done_lerr, stray_lerr);
        end
    endtask

    task automatic test_stall();
        int g0;
        bit to;
        g0 = gnt_cnt;
        gnt_delay = 4;
        stall_word = 1;
        stall_left = 5;
        start_job(0);
        wait_done(300, to);
        read_en = 1'b0;
        repeat (3) step();
        checks++;
        if (to || rx_cnt != 6 || exp_q.size() != 0 || stall_left != 0) begin
            errors++;
            $display("FAIL stall_words: got to=%0d words=%0d left=%0d stall=%0d required 0 6 0 0", to, rx_cnt, exp_q.size(), stall_left);
        end
        checks++;
        if (req_drops != 0 || gnt_cnt - g0 != 6) begin
            errors++;
            $display("FAIL stall_req: got drops=%0d grants=%0d required 0 6", req_drops, gnt_cnt - g0);
        end
        gnt_delay = 0;
        stall_word = -1;
    endtask

    task automatic test_release();
        int d0, bad;
        bit to;
        start_job(1);
        wait_done(100, to);
        d0 = done_cnt;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy !== 1'b1 || bus.mem_req || bus.out_valid) bad++;
        end
        checks++;
        if (to || bad != 0 || done_cnt != d0) begin
            errors++;
            $display("FAIL release_hold: got to=%0d bad=%0d extra_done=%0d required 0 0 0", to, bad, done_cnt - d0);
        end
        read_en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b required 0", busy); end
        step();
    endtask

    task automatic test_reset_mid();
        int d0, n;
        bit to;
        d0 = done_cnt;
        stall_word = 3;
        stall_left = 100;
        start_job(0);
        n = 0;
        while (!(bus.out_valid && rx_cnt == 3) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL rmid_reach: got no word 3 required word 3 in SEND"); end
        rst = 1'b1;
        read_en = 1'b0;
        step();
        checks++;
        if ({bus.out_valid, bus.mem_req, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_clear: got valid/req/busy %b required 000", {bus.out_valid, bus.mem_req, busy});
        end
        rst = 1'b0;
        stall_left = 0;
        stall_word = -1;
        exp_q.delete();
        repeat (5) step();
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL rmid_done: got %0d pulses required 0", done_cnt - d0); end
        start_job(0);
        wait_done(100, to);
        read_en = 1'b0;
        repeat (3) step();
        checks++;
        if (to || rx_cnt != 6 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL rmid_restart: got to=%0d words=%0d done=%0d required 0 6 1", to, rx_cnt, done_cnt - d0);
        end
    endtask

    initial begin : main
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 16; w++) mem[s][w] = 8'(8'h40 + 8'(s * 16 + w));
        mem[2][0] = 8'h11; mem[2][1] = 8'h05; mem[2][2] = 8'h02; mem[2][3] = 8'hA0; mem[2][4] = 8'hA1;
        mem[1][0] = 8'h01; mem[1][1] = 8'hC8; mem[1][2] = 8'h00;
        mem[0][0] = 8'h22; mem[0][1] = 8'h33; mem[0][2] = 8'h03;
        mem[0][3] = 8'hB0; mem[0][4] = 8'hB1; mem[0][5] = 8'hB2;
        mem[3][0] = 8'h5A; mem[3][1] = 8'h6B; mem[3][2] = 8'hFF;
        for (int w = 3; w < 16; w++) mem[3][w] = 8'(8'h80 + 8'(w));

        test_reset();
        test_basic();
        test_len_zero();
        test_len_err();
        test_stall();
        test_release();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
